load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store initiator sitting between the single-cycle core's execute stage and the word-only `data_memory`. It accepts one byte, halfword or word access per handshake and converts byte addresses to the word index the memory expects. It sign- or zero-extends sub-word loads, and performs sub-word stores as read-modify-write, because the memory has no byte enables. It returns each result through a valid/ready response channel.

## Interface
- `DATA_WIDTH`, 32: data path width; only 32 is supported.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request (high only in IDLE).
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_unsigned` input 1: zero-extend sub-word loads when 1, sign-extend when 0.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the low byte/half is used for sub-word stores.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: consumer accepts the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned access (only when `LSU_MISALIGN_CHECK_EN` is defined).
- `mem_a` output 32: word index to memory, equal to `{2'b00, addr[31:2]}`.
- `mem_wd` output 32: write data to memory.
- `mem_we` output 1: memory write enable; the memory writes on the same rising edge.
- `mem_rd` input 32: combinational read data from memory for the current `mem_a`.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch we/size/unsigned/addr/wdata.
  - Next state:
    - misaligned (with checking enabled) → RESP with err=1;
    - load → LOAD;
    - word store → STORE;
    - sub-word store → RMW_RD.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0. Byte accesses are never misaligned.
- LOAD:
  - `mem_a` is driven from the latched address.
  - Select the lane from `mem_rd` by addr[1:0]:
    - byte lanes: 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24];
    - half lanes: addr[1]=0 → [15:0], addr[1]=1 → [31:16].
  - Extend per `req_unsigned` and register the result into `resp_rdata`, then go to RESP.
- RMW_RD: drive `mem_a`, capture `mem_rd` into the merge register, then go to STORE.
- STORE:
  - `mem_we`=1.
  - `mem_wd` = wdata for a word store; for a sub-word store, the merge register with only the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Next state: RESP.
- RESP:
  - `resp_valid`=1; `resp_rdata`/`resp_err` are held stable.
  - Go to IDLE on `resp_ready`, otherwise stay.
- `mem_we` is 1 only in STORE. `mem_a` and `mem_wd` are 0 in IDLE and RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1 once `rst_n` is released (0 while asserted), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_a`=0, `mem_wd`=0, `mem_we`=0.
- Latency, with the request accepted at edge T and `resp_ready` held high:
  - load → `resp_valid` in cycle T+2;
  - word store → write at edge T+2, `resp_valid` in cycle T+2;
  - sub-word store → read in T+1, write at edge T+3, `resp_valid` in cycle T+3;
  - misaligned → `resp_valid` in cycle T+1, with no memory read and no write.
- Back-to-back: a new request can be accepted at the edge leaving RESP + 1. `req_ready` is 0 in RESP, so request and response never overlap.
- A request is not accepted in the same cycle RESP completes.
- `resp_ready` low stalls in RESP indefinitely; outputs hold.
- Reset mid-operation: all outputs go to reset values immediately. A reset during RMW_RD leaves memory untouched, because the write occurs only in STORE.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misaligned requests set `resp_err`=1 and perform no memory access.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - `resp_err` is tied 0;
  - halfword addresses are forced to addr[0]=0 and word addresses to addr[1:0]=0 before use;
  - the access then proceeds normally.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10 (`mem_a`=4, `mem_we` for 1 cycle); load word from 0x10 → `resp_rdata`=0xDEADBEEF at T+2.
- Byte loads: memory word 4 = 0x80FF7F01.
  - signed loads: 0x10 → 0x00000001, 0x11 → 0x0000007F, 0x12 → 0xFFFFFFFF, 0x13 → 0xFFFFFF80;
  - unsigned load: 0x13 → 0x00000080.
- Sub-word stores: word 4 = 0x11223344.
  - sb 0xAA at 0x11 → 0x1122AA44;
  - then sh 0xBEEF at 0x12 → 0xBEEFAA44, response at T+3.
- Misalignment, with the macro defined:
  - lw at 0x12 → `resp_err`=1 at T+1, `mem_we` never 1, memory unchanged;
  - without the macro, the same lw reads word 4 with `resp_err`=0.
- Backpressure: hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` stable and `req_ready`=0 throughout; the next request is accepted after the response handshake.
- Reset: deassert `rst_n` in RMW_RD of an sb → `mem_we` stays 0, memory word unchanged, outputs at reset values, `req_ready`=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core execute stage and a word-only data memory.
// Define LSU_MISALIGN_CHECK_EN to report misaligned accesses; otherwise low address bits are forced aligned.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_is_word, req_is_half;
  logic                  misalign;
  logic [31:0]           addr_use;
  logic [31:0]           word_idx;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign req_is_word = req_size[1];
  assign req_is_half = (req_size == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  assign addr_use = req_addr;
  assign misalign = (req_is_half && req_addr[0]) || (req_is_word && (req_addr[1:0] != 2'b00));
`else
  // Without checking, silently align the address to the access size.
  assign addr_use = {req_addr[31:2],
                     req_is_word ? 1'b0 : req_addr[1],
                     (req_is_word || req_is_half) ? 1'b0 : req_addr[0]};
  assign misalign = 1'b0;
`endif

  assign word_idx = {2'b00, addr_q[31:2]};

  always_comb begin
    byte_lane = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_lane = mem_rd[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{(DATA_WIDTH-8){~uns_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{(DATA_WIDTH-16){~uns_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rd;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the word read in RMW_RD.
  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_a   = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = addr_use;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misalign;
          if (misalign)         state_d = S_RESP;
          else if (!req_we)     state_d = S_LOAD;
          else if (req_is_word) state_d = S_STORE;
          else                  state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_a   = word_idx;
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        mem_a   = word_idx;
        merge_d = mem_rd;
        state_d = S_STORE;
      end
      S_STORE: begin
        mem_a   = word_idx;
        mem_we  = 1'b1;
        mem_wd  = size_q[1] ? wdata_q : merged;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  int          we_cnt;
  logic [31:0] last_wa;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[3:0]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_we) begin
      mem[mem_a[3:0]] <= mem_wd;
      we_cnt          <= we_cnt + 1;
      last_wa         <= mem_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    resp_ready   = (stall == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".req_ready_in_resp"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".stall_rdata"}, resp_rdata, exp_rd);
      chk({tag, ".stall_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".valid_after_hs"}, 32'(resp_valid), 32'd0);
    $display("xact %s we=%b size=%b addr=%h lat=%0d rdata=%h err=%b", tag, we, sz, addr, lat, resp_rdata, resp_err);
  endtask

  int cnt0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    pre_en = 1'b0; pre_idx = 4'd0; pre_val = 32'h0;
    we_cnt = 0; last_wa = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.mem_a", mem_a, 32'h0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.req_ready_rel", 32'(req_ready), 32'd1);

    // Word store then load.
    cnt0 = we_cnt;
    xact("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0);
    chk("sw.mem4", mem[4], 32'hDEADBEEF);
    chk("sw.we_pulses", 32'(we_cnt - cnt0), 32'd1);
    chk("sw.mem_a", last_wa, 32'd4);
    xact("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

    // Sub-word loads.
    preload(4'd4, 32'h80FF7F01);
    xact("lb10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 32'h00000001, 1'b0, 0);
    xact("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 32'h0000007F, 1'b0, 0);
    xact("lb12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0);
    xact("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0);
    xact("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 32'h00000080, 1'b0, 0);
    xact("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0);
    xact("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 32'h00007F01, 1'b0, 0);

    // Sub-word stores via read-modify-write.
    preload(4'd4, 32'h11223344);
    cnt0 = we_cnt;
    xact("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 3, 32'h0, 1'b0, 0);
    chk("sb11.mem4", mem[4], 32'h1122AA44);
    xact("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFEBEEF, 3, 32'h0, 1'b0, 0);
    chk("sh12.mem4", mem[4], 32'hBEEFAA44);
    chk("sub.we_pulses", 32'(we_cnt - cnt0), 32'd2);

    // Misaligned word load.
    cnt0 = we_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    xact("lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 32'h0, 1'b1, 0);
`else
    xact("lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 2, 32'hBEEFAA44, 1'b0, 0);
`endif
    chk("lw12.we_pulses", 32'(we_cnt - cnt0), 32'd0);
    chk("lw12.mem4", mem[4], 32'hBEEFAA44);

    // Backpressure, then an immediate follow-up request.
    xact("lw_stall", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hBEEFAA44, 1'b0, 5);
    xact("lbu13b", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 32'h000000BE, 1'b0, 0);

    // Reset during RMW_RD of a byte store.
    preload(4'd4, 32'h11223344);
    cnt0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rmwrst.mem_a_rd", mem_a, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("rmwrst.mem_a", mem_a, 32'h0);
    chk("rmwrst.mem_we", 32'(mem_we), 32'd0);
    chk("rmwrst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rmwrst.req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmwrst.req_ready_rel", 32'(req_ready), 32'd1);
    chk("rmwrst.mem4", mem[4], 32'h11223344);
    chk("rmwrst.we_pulses", 32'(we_cnt - cnt0), 32'd0);
    $display("xact rmw_reset addr=00000010 mem4=%h", mem[4]);
    xact("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h11223344, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
